// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the byte-stream program loader.
package prog_loader_pkg;

  localparam int ADDR_W         = 12;
  localparam int DATA_W         = 32;
  localparam int MAX_WORDS      = 4096;
  localparam int CSUM_W         = 8;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles big-endian words from accepted bytes and keeps the running XOR checksum.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        data_byte,
  output logic [DATA_W-1:0] word,
  output logic              last,
  output logic [CSUM_W-1:0] csum
);

  logic [1:0] byte_cnt;

  // The word register is left alone on clear so the last written word stays visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      word     <= '0;
      csum     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      csum     <= '0;
    end else if (shift) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= {word[DATA_W-9:0], data_byte};
      csum     <= csum ^ data_byte;
    end
  end

  assign last = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: frames a byte stream into program-memory writes and verifies the XOR checksum.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_t            state, state_next;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   n_words;
  logic [7:0]        len_hi;
  logic [15:0]       len_full;
  logic              len_bad;
  logic              xfer;
  logic              pk_shift;
  logic              pk_clear;
  logic              pk_last;
  logic              last_write;
  logic [DATA_W-1:0] pk_word;
  logic [CSUM_W-1:0] pk_csum;

  // Handshake and status outputs decode the state register only.
  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
  assign mem_we   = (state == S_WRITE);
  assign cpu_hold = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

  assign xfer       = in_valid && in_ready;
  assign len_full   = {len_hi, in_data};
  assign len_bad    = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
  assign pk_shift   = xfer && (state == S_DATA);
  assign pk_clear   = xfer && (state == S_LEN_LO);
  assign last_write = ((word_idx + IDX_ONE) == n_words);
  assign mem_wdata  = pk_word;

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift     (pk_shift),
    .data_byte (in_data),
    .word      (pk_word),
    .last      (pk_last),
    .csum      (pk_csum)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
      S_LEN_HI:              if (xfer) state_next = S_LEN_LO;
      S_LEN_LO:              if (xfer) state_next = len_bad ? S_ERR : S_DATA;
      S_DATA:                if (xfer && pk_last) state_next = S_WRITE;
      S_WRITE:               state_next = last_write ? S_CHECK : S_DATA;
      S_CHECK:               if (xfer) state_next = (in_data == pk_csum) ? S_DONE : S_ERR;
      default:               state_next = S_IDLE;
    endcase
  end

  // Word index is one bit wider than the address so a full 4096-word image never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_idx <= '0;
      n_words  <= '0;
      len_hi   <= '0;
      mem_addr <= '0;
    end else begin
      if (xfer && (state == S_LEN_HI)) len_hi <= in_data;
      if (xfer && (state == S_LEN_LO) && !len_bad) begin
        n_words  <= len_full[ADDR_W:0];
        word_idx <= '0;
      end
      if (pk_shift && pk_last) mem_addr <= word_idx[ADDR_W-1:0];
      if (state == S_WRITE)    word_idx <= word_idx + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] img [0:4095];
  logic [11:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Log every memory write; a byte must never be accepted while a word is being written.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      checkOutput("in_ready_in_write", {63'd0, in_ready}, 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit start_noise);
    int guard = 0;
    while ($urandom_range(0, 99) < gap_pct) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = start_noise && ($urandom_range(0, 3) == 0);
    end
    forever begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      start    = 1'b0;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        return;
      end
      guard++;
      if (guard > 200) begin
        checkOutput("byte_accept_timeout", 64'd0, 64'd1);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("cpu_hold_after_start", {63'd0, cpu_hold}, 64'd1);
    checkOutput("done_cleared", {63'd0, done}, 64'd0);
    checkOutput("error_cleared", {63'd0, error}, 64'd0);
  endtask

  // Sends one frame of img[0..n-1] and compares against the frame-level expectation.
  task automatic applyStimulus(input logic [15:0] n_field, input bit corrupt,
                               input int gap_pct, input bit start_noise);
    bit          len_ok;
    bit          exp_done;
    logic [7:0]  xsum;
    logic [7:0]  cs;
    int          n;
    int          cyc;
    n      = int'(n_field);
    len_ok = (n >= 1) && (n <= 4096);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(n_field[15:8], gap_pct, start_noise);
    send_byte(n_field[7:0], gap_pct, start_noise);
    if (!len_ok) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("badlen_error", {63'd0, error}, 64'd1);
      checkOutput("badlen_done", {63'd0, done}, 64'd0);
      checkOutput("badlen_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("badlen_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      checkOutput("badlen_writes", 64'(wr_addr_q.size()), 64'd0);
      return;
    end
    xsum = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b    = 8'(img[i] >> (24 - 8 * k));
        xsum = xsum ^ b;
        send_byte(b, gap_pct, start_noise);
      end
    end
    cs       = corrupt ? ((xsum == 8'h00) ? 8'hFF : 8'h00) : xsum;
    exp_done = !corrupt;
    send_byte(cs, gap_pct, start_noise);
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
    end while (!(done === 1'b1 || error === 1'b1) && cyc < 50);
    if (cyc >= 50) checkOutput("status_timeout", 64'd0, 64'd1);
    checkOutput("final_done", {63'd0, done}, {63'd0, exp_done});
    checkOutput("final_error", {63'd0, error}, {63'd0, !exp_done});
    checkOutput("final_cpu_hold", {63'd0, cpu_hold}, {63'd0, !exp_done});
    checkOutput("final_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("write_count", 64'(wr_addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      checkOutput("wr_addr", 64'(wr_addr_q[i]), 64'(i));
      checkOutput("wr_data", 64'(wr_data_q[i]), 64'(img[i]));
    end
  endtask

  task automatic load_test_words();
    img[0] = 32'h24010005;
    img[1] = 32'h24020007;
    img[2] = 32'h00221820;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_mem_we", {63'd0, mem_we}, 64'd0);
    checkOutput("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_error", {63'd0, error}, 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] 3-word frame, back-to-back");
    load_test_words();
    applyStimulus(16'h0003, 1'b0, 0, 1'b0);

    $display("[TB] 3-word frame, wrong checksum");
    applyStimulus(16'h0003, 1'b1, 0, 1'b0);

    $display("[TB] illegal lengths then a good frame");
    applyStimulus(16'h0000, 1'b0, 0, 1'b0);
    applyStimulus(16'h1001, 1'b0, 0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 0, 1'b0);

    $display("[TB] 3-word frame with valid gaps and stray start pulses");
    applyStimulus(16'h0003, 1'b0, 40, 1'b1);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      applyStimulus(16'(n), ($urandom_range(0, 2) == 0), $urandom_range(0, 50), 1'b1);
    end

    $display("[TB] reset in the middle of a load");
    load_test_words();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'(img[k / 4] >> (24 - 8 * (k % 4))), 0, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h18;
    @(negedge clk);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("midrst_mem_we", {63'd0, mem_we}, 64'd0);
    checkOutput("midrst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    checkOutput("midrst_error", {63'd0, error}, 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_writes", 64'(wr_addr_q.size()), 64'd1);
    checkOutput("midrst_idle_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;

    $display("[TB] full 4096-word image");
    for (int i = 0; i < 4096; i++) img[i] = 32'(i);
    applyStimulus(16'h1000, 1'b0, 0, 1'b0);
    if (wr_addr_q.size() > 0)
      checkOutput("full_last_addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 64'd4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
